pcm_capture_ctrl: RTL and testbench
===================================

# pcm_capture_ctrl

Sequencer for the PDM-to-PCM decimation path. Holds the CIC decimator in reset while idle and releases it on a start request. It then discards the CIC start-up transient and streams decimated PCM samples, framed into fixed-length frames, over a valid/ready interface to the speech-feature front end. Sits between the CIC decimator (driving its reset and clock enable, consuming its `ce_out` strobe and PCM output) and the frame buffer.

## Interface
- `PCM_WIDTH`, 16, PCM sample width (matches CIC output).
- `FRAME_LEN`, 256, samples per frame; ≥ 2.
- `WARMUP_SAMPLES`, 8, CIC output strobes discarded after release; 0 allowed.
- `MAX_FRAMES`, 0, frames captured per start; 0 = continuous until stop.

- `i_clk` in 1: system clock; PDM sampling clock, same as CIC.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: single-cycle start request.
- `i_stop` in 1: single-cycle stop request.
- `o_cic_rst_n` out 1: active-low reset to CIC.
- `o_cic_enable` out 1: CIC `clk_enable`.
- `i_cic_ce` in 1: CIC `ce_out` strobe, one cycle per output sample.
- `i_cic_pcm` in PCM_WIDTH: CIC PCM output, signed.
- `o_pcm_valid` out 1: output sample valid.
- `i_pcm_ready` in 1: downstream accepts.
- `o_pcm_data` out PCM_WIDTH: output sample, signed, unmodified.
- `o_pcm_first` out 1: sample is index 0 of its frame.
- `o_pcm_last` out 1: sample is index FRAME_LEN-1.
- `o_busy` out 1: state ≠ IDLE.
- `o_done` out 1: one-cycle pulse on DRAIN→IDLE.
- `o_ovf` out 1: sticky overflow; cleared on accepted start.
- `o_drop_cnt` out 16: dropped-sample count (see Configuration).

## Operation
- States: IDLE, WARMUP, CAPTURE, DRAIN.
- IDLE: `o_cic_rst_n`=0, `o_cic_enable`=0. `i_start` clears counters and `o_ovf`, then goes to WARMUP. If WARMUP_SAMPLES=0, it goes directly to CAPTURE. `i_stop` is ignored; `i_start` with `i_stop` in IDLE is a start.
- WARMUP/CAPTURE: `o_cic_rst_n`=1, `o_cic_enable`=1.
- WARMUP: counts `i_cic_ce` and discards the samples. The WARMUP_SAMPLES-th strobe moves to CAPTURE. `i_stop` returns to IDLE next cycle with no output.
- CAPTURE: each `i_cic_ce` loads one sample into a one-entry output register.
  - Sets valid, and `first`/`last` from the sample index counter.
  - The index wraps FRAME_LEN-1→0; the frame counter increments on index FRAME_LEN-1.
- Overflow: `i_cic_ce` while valid && !ready drops the new sample.
  - Set `o_ovf` and increment the drop counter.
  - The index and frame counter still advance, so frames stay time-aligned.
- Simultaneous accept and load (valid && ready && `i_cic_ce`): no overflow; the register reloads.
- Stop in CAPTURE: completes the current frame, then enters DRAIN after index FRAME_LEN-1 is loaded. If index=0 (frame not begun), DRAIN is entered next cycle.
- MAX_FRAMES≠0: DRAIN after the MAX_FRAMES-th frame's last strobe.
- DRAIN: `o_cic_enable`=0, `o_cic_rst_n`=1. Waits until the output register is empty, then IDLE with an `o_done` pulse. If already empty on entry, IDLE comes next cycle.
- `i_start` outside IDLE is ignored.
- `o_pcm_data`, `o_pcm_first` and `o_pcm_last` hold stable while valid && !ready.

## Timing
- Reset values:
  - all outputs 0, including `o_cic_rst_n` (CIC held in reset);
  - state IDLE;
  - counters 0.
- Start→`o_cic_rst_n`/`o_cic_enable` high: 1 cycle (registered).
- `i_cic_ce`→`o_pcm_valid`: 1 cycle.
- Valid drops the cycle after a ready handshake unless reloaded.
- Asynchronous reset mid-frame:
  - all state lost; valid deasserts immediately;
  - CIC re-held in reset; no `o_done`.
- All outputs registered; no combinational ready→valid path.

## Configuration
- `PCM_CAPTURE_DROP_CNT_EN` defined: 16-bit saturating (stops at 0xFFFF) drop counter on `o_drop_cnt`, cleared on accepted start.
- Undefined: counter logic removed, `o_drop_cnt` tied to 0. `o_ovf` is always present.

## Structure
- `pcm_capture_pkg`: state enum typedef, default PCM_WIDTH constant, drop-counter width constant.
- Sub-module `pcm_hold_reg`: one-entry valid/ready output register carrying data + first/last. Reports load-while-full as an overflow strobe.

## Test plan
- WARMUP_SAMPLES=8, FRAME_LEN=4, ready=1, start, 16 CIC strobes with data 1..16 → outputs 9..16; first on 9 and 13; last on 12 and 16; `o_ovf`=0.
- MAX_FRAMES=2, FRAME_LEN=4, WARMUP=0, start, continuous strobes → exactly 8 samples out; `o_cic_enable` low after the 8th strobe; `o_done` pulses once; `o_busy` low.
- Ready held 0 across 3 strobes → first sample held stable; `o_ovf`=1; drop count 2 with macro, 0 without. Next frame's first flag still on schedule.
- Stop after index 1 of FRAME_LEN=4 → indices 2,3 still delivered, then DRAIN→IDLE. Stop during WARMUP → IDLE, no `o_pcm_valid`, no `o_done`.
- Ready and strobe in the same cycle for 32 consecutive strobes → no overflow, every sample delivered in order.
- Assert `i_rst_n`=0 mid-frame with valid=1 → valid, `o_cic_rst_n`, `o_busy` immediately 0. A fresh start after release restarts at index 0.

Source files
------------

// File: rtl/pcm_capture_pkg.sv
// pcm_capture_pkg: shared types and constants for the PDM-to-PCM capture sequencer.
package pcm_capture_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;
  localparam int PCM_WIDTH_DEF = 16;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/pcm_hold_reg.sv
// pcm_hold_reg: one-entry valid/ready output register carrying PCM data plus frame flags;
// a load that arrives while full and not draining is refused and flagged on o_ovf.
module pcm_hold_reg #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_first,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_first,
  output logic         o_last,
  output logic         o_ovf
);
  logic         valid_q, valid_d, first_q, first_d, last_q, last_d, accept;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    accept  = i_load && (!valid_q || i_ready);
    o_ovf   = i_load && valid_q && !i_ready;
    valid_d = accept ? 1'b1 : valid_q && !i_ready;
    data_d  = accept ? i_data : data_q;
    first_d = accept ? i_first : first_q;
    last_d  = accept ? i_last : last_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_first = first_q;
  assign o_last  = last_q;
endmodule

// File: rtl/pcm_capture_ctrl.sv
// pcm_capture_ctrl: CIC reset/enable sequencing, warm-up discard and framed PCM streaming.
// Define PCM_CAPTURE_DROP_CNT_EN to build the saturating dropped-sample counter.
module pcm_capture_ctrl
  import pcm_capture_pkg::*;
#(
  parameter int PCM_WIDTH      = PCM_WIDTH_DEF,
  parameter int FRAME_LEN      = 256,
  parameter int WARMUP_SAMPLES = 8,
  parameter int MAX_FRAMES     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic                  o_cic_rst_n,
  output logic                  o_cic_enable,
  input  logic                  i_cic_ce,
  input  logic [PCM_WIDTH-1:0]  i_cic_pcm,
  output logic                  o_pcm_valid,
  input  logic                  i_pcm_ready,
  output logic [PCM_WIDTH-1:0]  o_pcm_data,
  output logic                  o_pcm_first,
  output logic                  o_pcm_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovf,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int WW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam int FW = 16;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [WW-1:0] warm_q, warm_d;
  logic          stop_q, stop_d, ovf_q, done_q, cic_rst_n_q, cic_en_q, busy_q;
  logic          load, idx_last, frame_end, start_acc, hold_ovf;

  assign start_acc = (state_q == ST_IDLE) && i_start;
  assign idx_last  = idx_q == IW'(FRAME_LEN - 1);
  assign frame_end = (MAX_FRAMES != 0) && (frame_q == FW'(MAX_FRAMES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    warm_d  = warm_q;
    stop_d  = stop_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE:
        if (i_start) begin
          idx_d   = '0;
          frame_d = '0;
          warm_d  = '0;
          stop_d  = 1'b0;
          state_d = (WARMUP_SAMPLES == 0) ? ST_CAPTURE : ST_WARMUP;
        end
      ST_WARMUP:
        if (i_stop) state_d = ST_IDLE;
        else if (i_cic_ce) begin
          warm_d = warm_q + 1'b1;
          if (warm_q == WW'(WARMUP_SAMPLES - 1)) state_d = ST_CAPTURE;
        end
      ST_CAPTURE:
        // a stop between frames drains at once; mid-frame it waits for the frame's last strobe
        if (i_stop && idx_q == '0) state_d = ST_DRAIN;
        else begin
          stop_d = stop_q | i_stop;
          if (i_cic_ce) begin
            load  = 1'b1;
            idx_d = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) begin
              frame_d = frame_q + 1'b1;
              if (stop_d || frame_end) state_d = ST_DRAIN;
            end
          end
        end
      ST_DRAIN:
        if (!o_pcm_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      warm_q      <= '0;
      stop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      cic_rst_n_q <= 1'b0;
      cic_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      warm_q      <= warm_d;
      stop_q      <= stop_d;
      ovf_q       <= start_acc ? 1'b0 : ovf_q | hold_ovf;
      done_q      <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      cic_rst_n_q <= state_d != ST_IDLE;
      cic_en_q    <= (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
      busy_q      <= state_d != ST_IDLE;
    end
  end

  pcm_hold_reg #(.W(PCM_WIDTH)) u_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load),
    .i_data  (i_cic_pcm),
    .i_first (idx_q == '0),
    .i_last  (idx_last),
    .i_ready (i_pcm_ready),
    .o_valid (o_pcm_valid),
    .o_data  (o_pcm_data),
    .o_first (o_pcm_first),
    .o_last  (o_pcm_last),
    .o_ovf   (hold_ovf)
  );

`ifdef PCM_CAPTURE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_q <= '0;
    else if (start_acc) drop_q <= '0;
    else if (hold_ovf && drop_q != '1) drop_q <= drop_q + 1'b1;
  end
  assign o_drop_cnt = drop_q;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_cic_rst_n  = cic_rst_n_q;
  assign o_cic_enable = cic_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_ovf        = ovf_q;
endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// tb_pcm_capture_ctrl: directed and randomized checks of pcm_capture_ctrl against a sample-level model.
module tb_pcm_capture_ctrl;
  localparam int W  = 8;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, ce = 1'b0, ready = 1'b0;
  logic [15:0] pcm = '0;
  logic        a_cic_rst_n, a_cic_en, a_valid, a_first, a_last, a_busy, a_done, a_ovf;
  logic [15:0] a_data, a_drop;

  logic        b_start = 1'b0, b_ce = 1'b0, b_stop = 1'b0, b_ready = 1'b1;
  logic [15:0] b_pcm = '0;
  logic        b_cic_rst_n, b_cic_en, b_valid, b_first, b_last, b_busy, b_done, b_ovf;
  logic [15:0] b_data, b_drop;

  int checks = 0, errors = 0;
  int k, m_drop, m_del, n_del, n_done, n_first, n_last;
  logic m_cap, m_stop, m_valid, m_first, m_last, m_ovf;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  pcm_capture_ctrl #(.PCM_WIDTH(16), .FRAME_LEN(FL), .WARMUP_SAMPLES(W), .MAX_FRAMES(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .o_cic_rst_n(a_cic_rst_n), .o_cic_enable(a_cic_en), .i_cic_ce(ce), .i_cic_pcm(pcm),
    .o_pcm_valid(a_valid), .i_pcm_ready(ready), .o_pcm_data(a_data), .o_pcm_first(a_first),
    .o_pcm_last(a_last), .o_busy(a_busy), .o_done(a_done), .o_ovf(a_ovf), .o_drop_cnt(a_drop)
  );

  pcm_capture_ctrl #(.PCM_WIDTH(16), .FRAME_LEN(FL), .WARMUP_SAMPLES(0), .MAX_FRAMES(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_stop(b_stop),
    .o_cic_rst_n(b_cic_rst_n), .o_cic_enable(b_cic_en), .i_cic_ce(b_ce), .i_cic_pcm(b_pcm),
    .o_pcm_valid(b_valid), .i_pcm_ready(b_ready), .o_pcm_data(b_data), .o_pcm_first(b_first),
    .o_pcm_last(b_last), .o_busy(b_busy), .o_done(b_done), .o_ovf(b_ovf), .o_drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop(input int d);
`ifdef PCM_CAPTURE_DROP_CNT_EN
    return 32'(d);
`else
    return 32'(d * 0);
`endif
  endfunction

  task automatic check_out();
    chk("valid", a_valid, m_valid);
    if (m_valid) begin
      chk("data", a_data, m_data);
      chk("first", a_first, m_first);
      chk("last", a_last, m_last);
    end
    chk("ovf", a_ovf, m_ovf);
    chk("drop", a_drop, exp_drop(m_drop));
  endtask

  // one clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic c, input logic [15:0] d, input logic r, input logic s);
    int j;
    ce = c; pcm = d; ready = r; stop = s;
    if (a_valid && r) begin
      n_del++;
      if (a_first) n_first++;
      if (a_last) n_last++;
    end
    if (m_valid && r) m_del++;
    if (s && m_cap) begin
      if (k < W || (k - W) % FL == 0) m_cap = 1'b0;
      else m_stop = 1'b1;
    end
    if (m_cap && c) begin
      k++;
      if (k > W) begin
        j = (k - W - 1) % FL;
        if (m_valid && !r) begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end else begin
          m_valid = 1'b1; m_data = d; m_first = (j == 0); m_last = (j == FL - 1);
        end
        if (j == FL - 1 && m_stop) m_cap = 1'b0;
      end
    end else if (m_valid && r) m_valid = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0; stop = 1'b0;
    if (a_done) n_done++;
    check_out();
  endtask

  task automatic do_start();
    start = 1'b1; ce = 1'b0; ready = 1'b1;
    if (m_valid) m_valid = 1'b0;
    k = 0; m_cap = 1'b1; m_stop = 1'b0; m_ovf = 1'b0; m_drop = 0;
    n_del = 0; m_del = 0; n_done = 0; n_first = 0; n_last = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_cic_rst_n", a_cic_rst_n, 1);
    chk("start_cic_en", a_cic_en, 1);
    chk("start_busy", a_busy, 1);
    check_out();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && a_busy; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("idle_busy", a_busy, 0);
    chk("idle_cic_rst_n", a_cic_rst_n, 0);
    chk("idle_cic_en", a_cic_en, 0);
  endtask

  task automatic warmup();
    for (int i = 0; i < W; i++) step(1'b1, 16'(16'hE000 + i), 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] b_got[$];
    int nb_done;
    m_valid = 1'b0; m_cap = 1'b0; m_stop = 1'b0; m_ovf = 1'b0; m_drop = 0; k = 0;
    m_first = 1'b0; m_last = 1'b0; m_data = '0;
    n_del = 0; m_del = 0; n_done = 0; n_first = 0; n_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cic_rst_n", a_cic_rst_n, 0);
    chk("rst_cic_en", a_cic_en, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_cic_rst_n", b_cic_rst_n, 0);
    check_out();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MAX_FRAMES=2 instance: exactly two frames, then drain and done
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; nb_done = 0;
    for (int i = 0; i < 14; i++) begin
      b_ce = (i < 12); b_pcm = 16'(100 + i);
      if (b_valid) b_got.push_back(b_data);
      @(posedge clk); #1;
      if (b_done) nb_done++;
      if (i == 6) chk("b_en_before_last", b_cic_en, 1);
      if (i == 7) chk("b_en_after_last", b_cic_en, 0);
    end
    b_ce = 1'b0;
    chk("b_count", b_got.size(), 8);
    for (int i = 0; i < b_got.size(); i++) chk("b_data", b_got[i], 100 + i);
    chk("b_done", nb_done, 1);
    chk("b_busy", b_busy, 0);

    // warm-up discard and frame flags
    do_start();
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    wait_idle();
    chk("t1_delivered", n_del, 8);
    chk("t1_firsts", n_first, 2);
    chk("t1_lasts", n_last, 2);
    chk("t1_done", n_done, 1);

    // overflow while ready is low
    do_start();
    warmup();
    step(1'b1, 16'd100, 1'b0, 1'b0);
    step(1'b1, 16'd101, 1'b0, 1'b0);
    step(1'b1, 16'd102, 1'b0, 1'b0);
    chk("t2_held", a_data, 100);
    chk("t2_ovf", a_ovf, 1);
    chk("t2_drop", a_drop, exp_drop(2));
    step(1'b1, 16'd103, 1'b1, 1'b0);
    step(1'b1, 16'd104, 1'b1, 1'b0);
    chk("t2_next_first", a_first, 1);
    for (int i = 105; i <= 107; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    wait_idle();
    chk("t2_ovf_sticky", a_ovf, 1);

    // stop mid-frame completes the frame
    do_start();
    chk("t3_ovf_cleared", a_ovf, 0);
    warmup();
    step(1'b1, 16'd200, 1'b1, 1'b0);
    step(1'b1, 16'd201, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b1, 16'd202, 1'b1, 1'b0);
    step(1'b1, 16'd203, 1'b1, 1'b0);
    chk("t3_drain_en", a_cic_en, 0);
    chk("t3_drain_rst_n", a_cic_rst_n, 1);
    step(1'b1, 16'd204, 1'b1, 1'b0);
    wait_idle();
    chk("t3_delivered", n_del, 4);
    chk("t3_done", n_done, 1);

    // stop during warm-up
    do_start();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    chk("t4_busy", a_busy, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    chk("t4_delivered", n_del, 0);
    chk("t4_done", n_done, 0);

    // back-to-back accept and load, then random traffic
    do_start();
    warmup();
    for (int i = 0; i < 32; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    chk("t5_no_ovf", a_ovf, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    wait_idle();
    chk("t5_delivered", n_del, m_del);
    chk("t5_done", n_done, 1);

    // asynchronous reset mid-frame
    do_start();
    warmup();
    step(1'b1, 16'h0300, 1'b0, 1'b0);
    step(1'b1, 16'h0301, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", a_valid, 0);
    chk("t6_cic_rst_n", a_cic_rst_n, 0);
    chk("t6_busy", a_busy, 0);
    m_valid = 1'b0; m_cap = 1'b0; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    chk("t6_done", a_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    warmup();
    step(1'b1, 16'h0400, 1'b1, 1'b0);
    chk("t6_restart_first", a_first, 1);
    step(1'b1, 16'h0401, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
